// File: rtl/skew_feed_pkg.sv
// Shared types for the skewed operand feeder: FSM state encoding and
// drain-counter sizing.
package skew_feed_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // A one-lane array still needs a 1-bit counter so the port list stays legal.
  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// One lane of the skew: DEPTH-stage data+valid shift register, 1 output per
// cycle, no stall -- the line shifts every clock and clears synchronously.
module lane_delay
  import skew_feed_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o
);

  logic [DW-1:0]    dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
      vld_q <= '0;
    end else begin
      dat_q[0] <= dat_i;
      vld_q[0] <= vld_i;
      for (int k = 1; k < DEPTH; k++) begin
        dat_q[k] <= dat_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign dat_o = dat_q[DEPTH-1];
  assign vld_o = vld_q[DEPTH-1];

endmodule

// File: rtl/skew_feed.sv
// Feeds a systolic array edge: lane i sees an accepted vector i+1 cycles later.
// in_ready only in STREAM; the array side cannot stall the delay lines.
module skew_feed
  import skew_feed_pkg::*;
#(
  parameter int M  = 3,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [DW-1:0] a_in [0:M-1],
  output logic          in_ready,
  output logic [DW-1:0] a_out [0:M-1],
  output logic [M-1:0]  lane_valid,
  output logic          busy,
  output logic          done
);

  localparam int            CW         = cnt_width(M);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'((M > 1) ? M - 2 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign in_ready = (state_q == STREAM);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DRAIN holds until the deepest lane presents the last beat, so done lines
  // up with lane M-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = STREAM;
      end
      STREAM: begin
        if (accept && in_last) begin
          if (M > 1) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Non-accepted cycles inject zeros so nothing stale ever reaches the array.
  for (genvar i = 0; i < M; i++) begin : g_lane
    lane_delay #(
      .DW   (DW),
      .DEPTH(i + 1)
    ) u_lane (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .vld_i (accept),
      .dat_i (accept ? a_in[i] : '0),
      .vld_o (lane_valid[i]),
      .dat_o (a_out[i])
    );
  end

endmodule

// File: tb/tb_skew_feed.sv
// Drives four skew_feed configurations (M=3, 4, 1, 8) from shared stimulus and
// compares the selected one against a cycle-indexed model of accepted beats.
module tb_skew_feed;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N, start, in_valid, in_last;
  logic [7:0][15:0] a_in;
  int sel;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  a3_i [0:2]; logic [7:0]  a3_o [0:2]; logic [2:0] lv3; logic rdy3, busy3, done3;
  logic [7:0]  a4_i [0:3]; logic [7:0]  a4_o [0:3]; logic [3:0] lv4; logic rdy4, busy4, done4;
  logic [7:0]  a1_i [0:0]; logic [7:0]  a1_o [0:0]; logic [0:0] lv1; logic rdy1, busy1, done1;
  logic [15:0] a8_i [0:7]; logic [15:0] a8_o [0:7]; logic [7:0] lv8; logic rdy8, busy8, done8;

  always_comb begin
    for (int i = 0; i < 3; i++) a3_i[i] = a_in[i][7:0];
    for (int i = 0; i < 4; i++) a4_i[i] = a_in[i][7:0];
    a1_i[0] = a_in[0][7:0];
    for (int i = 0; i < 8; i++) a8_i[i] = a_in[i];
  end

  skew_feed #(.M(3), .DW(8)) u3 (.CLK(CLK), .RST_N(RST_N), .start(start && sel == 0),
    .in_valid(in_valid), .in_last(in_last), .a_in(a3_i), .in_ready(rdy3), .a_out(a3_o),
    .lane_valid(lv3), .busy(busy3), .done(done3));
  skew_feed #(.M(4), .DW(8)) u4 (.CLK(CLK), .RST_N(RST_N), .start(start && sel == 1),
    .in_valid(in_valid), .in_last(in_last), .a_in(a4_i), .in_ready(rdy4), .a_out(a4_o),
    .lane_valid(lv4), .busy(busy4), .done(done4));
  skew_feed #(.M(1), .DW(8)) u1 (.CLK(CLK), .RST_N(RST_N), .start(start && sel == 2),
    .in_valid(in_valid), .in_last(in_last), .a_in(a1_i), .in_ready(rdy1), .a_out(a1_o),
    .lane_valid(lv1), .busy(busy1), .done(done1));
  skew_feed #(.M(8), .DW(16)) u8 (.CLK(CLK), .RST_N(RST_N), .start(start && sel == 3),
    .in_valid(in_valid), .in_last(in_last), .a_in(a8_i), .in_ready(rdy8), .a_out(a8_o),
    .lane_valid(lv8), .busy(busy8), .done(done8));

  logic [7:0][15:0] o_dat;
  logic [7:0]       o_lv;
  logic             o_rdy, o_busy, o_done;
  logic [138:0]     obs;

  always_comb begin
    o_dat = '0; o_lv = '0; o_rdy = 1'b0; o_busy = 1'b0; o_done = 1'b0;
    case (sel)
      0: begin
        for (int i = 0; i < 3; i++) o_dat[i] = {8'h00, a3_o[i]};
        o_lv[2:0] = lv3; o_rdy = rdy3; o_busy = busy3; o_done = done3;
      end
      1: begin
        for (int i = 0; i < 4; i++) o_dat[i] = {8'h00, a4_o[i]};
        o_lv[3:0] = lv4; o_rdy = rdy4; o_busy = busy4; o_done = done4;
      end
      2: begin
        o_dat[0] = {8'h00, a1_o[0]};
        o_lv[0] = lv1[0]; o_rdy = rdy1; o_busy = busy1; o_done = done1;
      end
      3: begin
        for (int i = 0; i < 8; i++) o_dat[i] = a8_o[i];
        o_lv = lv8; o_rdy = rdy8; o_busy = busy8; o_done = done8;
      end
      default: ;
    endcase
  end
  assign obs = {o_rdy, o_busy, o_done, o_lv, o_dat};

  // Model: accepted vectors keyed by acceptance cycle, plus tile start/last cycles.
  logic [7:0][15:0] acc [int];
  bit in_tile;
  int start_cyc, last_cyc;

  function automatic int cur_m();
    case (sel)
      0: return 3;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [15:0] cur_mask();
    return (sel == 3) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic bit m_ready();
    return in_tile && cyc > start_cyc && last_cyc < 0;
  endfunction

  function automatic bit m_busy();
    return in_tile && cyc > start_cyc && (last_cyc < 0 || cyc <= last_cyc + cur_m());
  endfunction

  function automatic logic [138:0] model_exp();
    logic [7:0][15:0] d;
    logic [7:0] lv;
    bit dn;
    d = '0; lv = '0;
    for (int i = 0; i < cur_m(); i++) begin
      if (acc.exists(cyc - 1 - i)) begin
        d[i]  = acc[cyc - 1 - i][i];
        lv[i] = 1'b1;
      end
    end
    dn = in_tile && last_cyc >= 0 && cyc == last_cyc + cur_m();
    return {m_ready(), m_busy(), dn, lv, d};
  endfunction

  task automatic step();
    logic [7:0][15:0] v;
    bit idle;
    idle = !m_busy();
    if (!RST_N) begin
      in_tile = 1'b0; last_cyc = -1; acc.delete();
    end else begin
      if (m_ready() && in_valid) begin
        v = '0;
        for (int i = 0; i < cur_m(); i++) v[i] = a_in[i] & cur_mask();
        acc[cyc] = v;
        if (in_last) last_cyc = cyc;
      end
      if (idle && start) begin
        in_tile = 1'b1; start_cyc = cyc; last_cyc = -1;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit s, input bit v, input bit l);
    start = s; in_valid = v; in_last = l;
    for (int i = 0; i < 8; i++) a_in[i] = 16'($urandom);
  endtask

  task automatic set_sel(input int n);
    sel = n; in_tile = 1'b0; last_cyc = -1; acc.delete();
  endtask

  task automatic flush();
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b1, 1'b1);
      step();
    end
  endtask

  task automatic test_reset();
    set_sel(0);
    for (int k = 0; k < 8; k++) begin
      RST_N = (k >= 3);
      drive(k < 3, 1'b1, $urandom_range(0, 1) == 1);
      @(negedge CLK);
      checks++;
      if (obs !== '0) begin
        errors++; $display("FAIL reset_state cyc=%0d got=%h exp=0", k, obs);
      end
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", k, obs, model_exp());
      end
      step();
    end
  endtask

  task automatic test_basic();
    set_sel(0);
    for (int k = 0; k < 12; k++) begin
      drive(k == 0, k >= 1 && k <= 3, k == 3);
      if (k >= 1 && k <= 3) for (int i = 0; i < 3; i++) a_in[i] = 16'(3 * (k - 1) + i + 1);
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", k, obs, model_exp());
      end
      if (k == 4) begin
        checks++;
        if ({o_lv, o_dat[0], o_dat[1], o_dat[2]} !== {8'h07, 16'd7, 16'd5, 16'd3}) begin
          errors++; $display("FAIL basic_skew cyc=4 got=%h exp=07000700050003",
                             {o_lv, o_dat[0], o_dat[1], o_dat[2]});
        end
      end
      if (k >= 5 && k <= 7) begin
        checks++;
        if ({o_done, o_busy} !== {k == 6, k <= 6}) begin
          errors++; $display("FAIL basic_done cyc=%0d got=%b%b", k, o_done, o_busy);
        end
      end
      step();
    end
  endtask

  task automatic test_bubble();
    set_sel(0);
    for (int k = 0; k < 12; k++) begin
      drive(k == 0, k == 1 || k == 3, k == 3);
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL bubble cyc=%0d got=%h exp=%h", k, obs, model_exp());
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    set_sel(1);
    RST_N = 1'b1;
    for (int k = 0; k < 16; k++) begin
      RST_N = (k != 3);
      drive(k == 0, k >= 1, 1'b0);
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k, obs, model_exp());
      end
      if (k >= 4) begin
        checks++;
        if (obs !== '0) begin
          errors++; $display("FAIL reset_mid_residue cyc=%0d got=%h exp=0", k, obs);
        end
      end
      step();
    end
    RST_N = 1'b1;
  endtask

  task automatic test_single();
    set_sel(2);
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, k == 1, k == 1);
      if (k == 1) a_in[0] = 16'h00A5;
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL single cyc=%0d got=%h exp=%h", k, obs, model_exp());
      end
      if (k == 2) begin
        checks++;
        if ({o_done, o_lv[0], o_dat[0]} !== {2'b11, 16'h00A5}) begin
          errors++; $display("FAIL single_out cyc=2 got=%h exp=300a5", {o_done, o_lv[0], o_dat[0]});
        end
      end
      step();
    end
  endtask

  task automatic test_ignored();
    set_sel(0);
    for (int k = 0; k < 16; k++) begin
      drive(k == 3 || (k >= 6 && k <= 8), k < 3 || k == 4 || k == 5 || k >= 9, k == 5);
      if (k < 3 || k >= 9) for (int i = 0; i < 8; i++) a_in[i] = 16'h00FF;
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL ignored cyc=%0d got=%h exp=%h", k, obs, model_exp());
      end
      if (k < 3 || k >= 9) begin
        checks++;
        if (obs !== '0) begin
          errors++; $display("FAIL ignored_idle cyc=%0d got=%h exp=0", k, obs);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    set_sel(3);
    for (int k = 0; k < 20; k++) begin
      drive(k == 0, k >= 1 && k <= 8, k == 8);
      @(negedge CLK);
      checks++;
      if (obs !== model_exp()) begin
        errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", k, obs, model_exp());
      end
      if (k >= 2 && k <= 9) begin
        checks++;
        if (o_lv[k-2] !== 1'b1 || (k < 9 && o_lv[k-1] !== 1'b0)) begin
          errors++; $display("FAIL b2b_first_valid cyc=%0d got=%b", k, o_lv);
        end
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (o_done !== (k == 16)) begin
          errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, o_done, k == 16);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      set_sel(n);
      for (int k = 0; k < 80; k++) begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        @(negedge CLK);
        checks++;
        if (obs !== model_exp()) begin
          errors++; $display("FAIL random sel=%0d cyc=%0d got=%h exp=%h", n, k, obs, model_exp());
        end
        step();
      end
      flush();
    end
  endtask

  initial begin
    RST_N = 1'b0;
    sel = 0;
    in_tile = 1'b0;
    start_cyc = 0;
    last_cyc = -1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) step();
    test_reset();
    test_basic();
    test_bubble();
    test_reset_mid();
    test_single();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
